// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the BCD calculator sequencer:
//   - sequencer state encoding
//   - keypad key codes
//   - ALU opcodes driven toward the two-digit BCD ALU
//   - operand digit-count limits
//   - debug struct exposing FSM state and operand digit counts
// ---------------------------------------------------------------------------
package calc_pkg;

  // Digits accepted per operand. Two packed BCD nibbles fill the 8-bit ALU.
  localparam int MAX_DIGITS = 2;
  localparam int CNT_W      = 2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_DIGITS);

  // ALU opcodes
  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b010;

  // Keypad codes: 0-9 are digits, 14-31 are reserved and ignored
  localparam logic [4:0] KEY_ADD = 5'd10;
  localparam logic [4:0] KEY_SUB = 5'd11;
  localparam logic [4:0] KEY_EQ  = 5'd12;
  localparam logic [4:0] KEY_CLR = 5'd13;

  typedef enum logic [1:0] {
    ENTER_OP1 = 2'd0,
    ENTER_OP2 = 2'd1,
    COMPUTE   = 2'd2,
    SHOW      = 2'd3
  } state_t;

  // Debug view of the sequencer, bound to by checkers
  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] op1_cnt;
    logic [CNT_W-1:0] op2_cnt;
  } dbg_t;

  function automatic logic is_digit(input logic [4:0] code);
    return (code <= 5'd9);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// ---------------------------------------------------------------------------
// bcd_entry_reg
// One packed-BCD operand register with a digit counter.
//   clk       : clock, rising edge
//   nrst      : synchronous active-low reset
//   clr       : clear value and count (highest priority after reset)
//   load_en   : parallel load of load_val / load_cnt
//   load_val  : packed BCD value to load
//   load_cnt  : digit count to associate with the loaded value
//   shift_en  : shift digit into the low nibble (ignored once count is full)
//   digit     : BCD digit 0-9
//   value     : packed BCD operand (registered)
//   count     : digits entered so far (registered)
// ---------------------------------------------------------------------------
module bcd_entry_reg
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             load_en,
  input  logic [7:0]       load_val,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             shift_en,
  input  logic [3:0]       digit,
  output logic [7:0]       value,
  output logic [CNT_W-1:0] count
);

  logic [7:0]       value_q, value_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clr) begin
      value_d = 8'h00;
      count_d = '0;
    end else if (load_en) begin
      value_d = load_val;
      count_d = load_cnt;
    end else if (shift_en && (count_q < CNT_FULL)) begin
      // Saturated register leaves value and count untouched
      value_d = {value_q[3:0], digit};
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      value_q <= 8'h00;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value = value_q;
  assign count = count_q;

endmodule

// File: rtl/bcd_calc_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_calc_sequencer
// Operand entry and sequencing for a two-digit BCD ALU. Keypad strobes build
// two operands, equals latches the ALU result, and chained operations reuse
// the previous result as the next op1.
//   clk          : clock, rising edge
//   nrst         : synchronous active-low reset
//   key_valid    : one-cycle strobe qualifying key_code
//   key_code     : 0-9 digit, 10 add, 11 sub, 12 equals, 13 clear, else ignored
//   alu_result   : packed BCD result from the combinational ALU
//   alu_c_out    : ALU most-significant-digit carry-out
//   op1, op2     : packed BCD operands to the ALU (registered)
//   opcode       : ALU opcode (registered)
//   display      : value to display (selected from registered state)
//   carry_flag   : carry-out of the last computation (registered)
//   result_valid : one-cycle pulse after the result is registered
//   busy         : high while in COMPUTE
//   dbg          : FSM state and operand digit counts
//
// Key interface: key_valid is a strobe with no back-pressure. A key is
// consumed on the rising edge where key_valid=1; there is no ready. Keys
// arriving while in COMPUTE (busy=1) are dropped, clear included.
// ---------------------------------------------------------------------------
module bcd_calc_sequencer
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic [7:0] alu_result,
  input  logic       alu_c_out,
  output logic [7:0] op1,
  output logic [7:0] op2,
  output logic [2:0] opcode,
  output logic [7:0] display,
  output logic       carry_flag,
  output logic       result_valid,
  output logic       busy,
  output dbg_t       dbg
);

  state_t     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       rv_q, rv_d;
  logic       busy_q, busy_d;

  // Operand register controls
  logic             op1_clr, op1_load, op1_shift;
  logic [7:0]       op1_load_val;
  logic [CNT_W-1:0] op1_load_cnt;
  logic             op2_clr, op2_shift;
  logic [CNT_W-1:0] op1_cnt, op2_cnt;

  // Key decode
  logic       key_digit, key_op, key_eq, key_clr;
  logic [2:0] key_opc;

  assign key_digit = key_valid && is_digit(key_code);
  assign key_op    = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
  assign key_eq    = key_valid && (key_code == KEY_EQ);
  assign key_clr   = key_valid && (key_code == KEY_CLR);
  assign key_opc   = (key_code == KEY_SUB) ? OPC_SUB : OPC_ADD;

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    result_d     = result_q;
    carry_d      = carry_q;
    rv_d         = 1'b0;
    op1_clr      = 1'b0;
    op1_load     = 1'b0;
    op1_shift    = 1'b0;
    op1_load_val = 8'h00;
    op1_load_cnt = '0;
    op2_clr      = 1'b0;
    op2_shift    = 1'b0;

    if (key_clr && (state_q != COMPUTE)) begin
      // Clear behaves like reset on the next edge
      state_d  = ENTER_OP1;
      opcode_d = OPC_ADD;
      result_d = 8'h00;
      carry_d  = 1'b0;
      op1_clr  = 1'b1;
      op2_clr  = 1'b1;
    end else begin
      case (state_q)
        ENTER_OP1: begin
          if (key_digit) begin
            op1_shift = 1'b1;
          end else if (key_op) begin
            opcode_d = key_opc;
            op2_clr  = 1'b1;
            state_d  = ENTER_OP2;
          end
        end
        ENTER_OP2: begin
          if (key_digit) begin
            op2_shift = 1'b1;
          end else if (key_op) begin
            opcode_d = key_opc;
          end else if (key_eq) begin
            state_d = COMPUTE;
          end
        end
        COMPUTE: begin
          // Operands have been stable on the ALU for a full cycle
          result_d = alu_result;
          carry_d  = alu_c_out;
          rv_d     = 1'b1;
          state_d  = SHOW;
        end
        SHOW: begin
          if (key_digit) begin
            op1_load     = 1'b1;
            op1_load_val = {4'h0, key_code[3:0]};
            op1_load_cnt = CNT_W'(1);
            carry_d      = 1'b0;
            state_d      = ENTER_OP1;
          end else if (key_op) begin
            // Chain: the previous result is a full operand, so further
            // digits for op1 are ignored
            op1_load     = 1'b1;
            op1_load_val = result_q;
            op1_load_cnt = CNT_FULL;
            opcode_d     = key_opc;
            op2_clr      = 1'b1;
            state_d      = ENTER_OP2;
          end
        end
        default: state_d = ENTER_OP1;
      endcase
    end

    busy_d = (state_d == COMPUTE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= ENTER_OP1;
      opcode_q <= OPC_ADD;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
    end
  end

  bcd_entry_reg u_op1 (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (op1_clr),
    .load_en  (op1_load),
    .load_val (op1_load_val),
    .load_cnt (op1_load_cnt),
    .shift_en (op1_shift),
    .digit    (key_code[3:0]),
    .value    (op1),
    .count    (op1_cnt)
  );

  // op2 is only ever shifted or cleared
  bcd_entry_reg u_op2 (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (op2_clr),
    .load_en  (1'b0),
    .load_val (8'h00),
    .load_cnt ('0),
    .shift_en (op2_shift),
    .digit    (key_code[3:0]),
    .value    (op2),
    .count    (op2_cnt)
  );

  // op2 is shown only once the user has started typing it
  always_comb begin
    display = op1;
    case (state_q)
      ENTER_OP1: display = op1;
      ENTER_OP2: display = (op2_cnt != '0) ? op2 : op1;
      COMPUTE:   display = (op2_cnt != '0) ? op2 : op1;
      SHOW:      display = result_q;
      default:   display = op1;
    endcase
  end

  assign opcode       = opcode_q;
  assign carry_flag   = carry_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign dbg          = '{state: state_q, op1_cnt: op1_cnt, op2_cnt: op2_cnt};

endmodule

// File: doc/bcd_calc_sequencer.md
Name: bcd_calc_sequencer

Overview:
Upstream operand-entry and sequencing stage for the two-digit BCD ALU. Accepts one-cycle keypad key strobes and accumulates up to two BCD digits per operand. Drives op1/op2/opcode into the ALU, registers the ALU result and carry-out, and presents the current display value. Supports chained operations, where the previous result becomes the next op1.

Parameters:
MAX_DIGITS, 2, digits accepted per operand; further digits are ignored. Fixed at 2 to match the 8-bit BCD ALU.
OPC_ADD, 3'b000, ALU opcode driven for addition.
OPC_SUB, 3'b010, ALU opcode driven for subtraction.

Ports:
clk  in  1  system clock, all state on rising edge
nrst  in  1  synchronous active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  5  0-9 digit, 10 add, 11 sub, 12 equals, 13 clear, 14-31 reserved
alu_result  in  8  packed BCD result from ALU (combinational)
alu_c_out  in  1  ALU MSD carry-out
op1  out  8  packed BCD operand 1 to ALU (registered)
op2  out  8  packed BCD operand 2 to ALU (registered)
opcode  out  3  ALU opcode (registered)
display  out  8  packed BCD value for display
carry_flag  out  1  registered alu_c_out of last computation
result_valid  out  1  one-cycle pulse when result is registered
busy  out  1  high in COMPUTE

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is synchronous, active-low. Reset is sampled on the rising edge and overrides everything, including a mid-computation reset.
- Reset values: state=ENTER_OP1; op1, op2 and result_reg = 8'h00; opcode=OPC_ADD; digit counters=0; carry_flag=0; result_valid=0; busy=0.
- Digit entry: reg <= {reg[3:0], digit}, count++. If count==MAX_DIGITS, the digit is ignored and the register is unchanged.
- Ignored keys: reserved codes (14-31) are ignored in every state. key_valid=0 means no action.
- ENTER_OP1:
  - Digit: shift into op1.
  - Add/sub: set opcode, clear op2 and its count, go to ENTER_OP2.
  - Equals: no-op.
  - display=op1.
- ENTER_OP2:
  - Digit: shift into op2.
  - Add/sub: replaces opcode, no state change.
  - Equals: go to COMPUTE. This is accepted even with zero op2 digits, in which case op2=00.
  - display=op2 if its count>0, else op1.
- COMPUTE (exactly one cycle, busy=1):
  - Register result_reg<=alu_result and carry_flag<=alu_c_out, pulse result_valid, go to SHOW.
  - Any key arriving in this cycle is dropped, including clear. Clear only takes effect from the next cycle.
- SHOW (display=result_reg):
  - Digit: op1<={4'h0,digit} with count=1, carry_flag<=0, go to ENTER_OP1.
  - Add/sub: op1<=result_reg with count=MAX_DIGITS (so further digits are ignored), set opcode, clear op2, go to ENTER_OP2.
  - Equals: no-op (no repeat-compute).
- Clear (code 13): in any state except COMPUTE, same effect as reset on the next edge.
- Latency: equals strobe at edge N gives state COMPUTE after N. At edge N+1, result_reg/carry_flag update and result_valid is high for the cycle following N+1.
- Arithmetic: this block does no arithmetic. It forwards packed BCD only. Digits are always 0-9 by construction, so the ALU never sees non-BCD nibbles from this block.
- Simultaneous events: at most one key per cycle by interface contract. The bench must not assert key_valid on consecutive cycles expecting both to be honoured in COMPUTE.

Decomposition:
- Package calc_pkg:
  - state enum (ENTER_OP1, ENTER_OP2, COMPUTE, SHOW).
  - key code localparams (KEY_ADD=10, KEY_SUB=11, KEY_EQ=12, KEY_CLR=13).
  - OPC_ADD/OPC_SUB constants.
- Sub-module bcd_entry_reg, instantiated twice (op1, op2). Ports: clk, nrst, clr, load_en, load_val, shift_en, digit. Outputs: value[7:0], count. It implements shifting, saturation at MAX_DIGITS, and load.

Test Plan:
- Keys 4,5,+,3,8,= -> op1=8'h45, op2=8'h38, opcode=000; result_valid one cycle after COMPUTE; display=8'h83, carry_flag=0.
- Keys 9,9,+,0,1,= -> display=8'h00, carry_flag=1.
- Keys 5,0,-,2,0,= with ALU instance connected -> opcode=010; display=8'h30, carry_flag=1 (no-borrow indication).
- Keys 1,2,3 -> op1=8'h12 (third digit ignored). Then 7,+,+,- -> opcode=010, state ENTER_OP2, display=8'h12.
- Chain 2,+,3,= then +,4,= -> second op1=8'h05; display=8'h09. Then digit 6 -> op1=8'h06, state ENTER_OP1, carry_flag=0.
- Clear issued during ENTER_OP2 and nrst=0 asserted during COMPUTE -> all outputs return to reset values on the next edge; code 15 in any state -> no change.
